// File: rtl/aes_128_sched_pkg.sv
// Shared types and defaults for the AES-128 request scheduler.
// Holds the FSM state encoding, default core latency/width and requester id type.
package aes_128_sched_pkg;

   localparam int DEF_LATENCY  = 21;
   localparam int DEF_KEY_BITS = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

   typedef logic req_id_t;

endpackage

// File: rtl/aes_tag_pipe.sv
// Fixed-depth shift pipeline of {valid, tag} that tracks blocks travelling
// through the AES core so each ciphertext can be matched to its requester.
module aes_tag_pipe #(
   parameter int DEPTH = 22,
   parameter int TAG_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             r_valid;
         logic [TAG_W-1:0] r_tag;
         logic             w_valid_in;
         logic [TAG_W-1:0] w_tag_in;

         if (gi == 0) begin : g_head
            assign w_valid_in = i_valid;
            assign w_tag_in   = i_tag;
         end else begin : g_body
            assign w_valid_in = g_stage[gi-1].r_valid;
            assign w_tag_in   = g_stage[gi-1].r_tag;
         end

         // Empty slots carry a zero tag so stale ids never linger.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_tag   <= '0;
            end else begin
               r_valid <= w_valid_in;
               r_tag   <= w_valid_in ? w_tag_in : '0;
            end
         end
      end
   endgenerate

   assign o_valid = g_stage[DEPTH-1].r_valid;
   assign o_tag   = g_stage[DEPTH-1].r_tag;

endmodule

// File: rtl/aes_128_sched.sv
// Two-requester round-robin front end for a fixed-latency aes_128 core:
// registers the winning operands, tags each block and returns ciphertext in order.
module aes_128_sched
   import aes_128_sched_pkg::*;
#(
   parameter int LATENCY  = DEF_LATENCY,
   parameter int KEY_BITS = DEF_KEY_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [KEY_BITS-1:0] req0_state,
   input  logic [KEY_BITS-1:0] req0_key,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [KEY_BITS-1:0] req1_state,
   input  logic [KEY_BITS-1:0] req1_key,
   input  logic                drain,
   output logic [KEY_BITS-1:0] core_state,
   output logic [KEY_BITS-1:0] core_key,
   input  logic [KEY_BITS-1:0] core_out,
   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [KEY_BITS-1:0] rsp_data,
   output logic                busy,
   output logic                drained
);

   localparam int DEPTH = LATENCY + 1;
   localparam int CNT_W = $clog2(LATENCY + 2);

   sched_state_e        r_state;
   sched_state_e        w_state_next;
   req_id_t             r_rr;
   logic [CNT_W-1:0]    r_inflight;
   logic [CNT_W-1:0]    w_inflight_next;
   logic [KEY_BITS-1:0] r_core_state;
   logic [KEY_BITS-1:0] r_core_key;

   logic    w_accept_ok;
   logic    w_grant0;
   logic    w_grant1;
   logic    w_hs;
   req_id_t w_winner;
   logic    w_tag_valid;
   req_id_t w_tag_id;

   // Drain wins over a same-cycle request, and nothing is granted under reset.
   assign w_accept_ok = !rst && !drain && (r_state != ST_DRAIN);
   assign w_grant0    = w_accept_ok && req0_valid && (!req1_valid || (r_rr == 1'b0));
   assign w_grant1    = w_accept_ok && req1_valid && (!req0_valid || (r_rr == 1'b1));
   assign w_hs        = w_grant0 || w_grant1;
   assign w_winner    = w_grant1;

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   aes_tag_pipe #(
      .DEPTH (DEPTH),
      .TAG_W ($bits(req_id_t))
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_hs),
      .i_tag   (w_winner),
      .o_valid (w_tag_valid),
      .o_tag   (w_tag_id)
   );

   always_comb begin
      w_inflight_next = r_inflight;
      if (w_hs && !w_tag_valid && (r_inflight != CNT_W'(DEPTH))) begin
         w_inflight_next = r_inflight + CNT_W'(1);
      end else if (!w_hs && w_tag_valid && (r_inflight != '0)) begin
         w_inflight_next = r_inflight - CNT_W'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (drain)     w_state_next = ST_DRAIN;
            else if (w_hs) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (drain)                                  w_state_next = ST_DRAIN;
            else if (!w_hs && (w_inflight_next == '0))  w_state_next = ST_IDLE;
         end
         ST_DRAIN: begin
            if (!drain && (r_inflight == '0)) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rr         <= 1'b0;
         r_inflight   <= '0;
         r_core_state <= '0;
         r_core_key   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= w_inflight_next;
         if (w_hs) begin
            r_rr         <= ~w_winner;
            r_core_state <= w_grant1 ? req1_state : req0_state;
            r_core_key   <= w_grant1 ? req1_key   : req0_key;
         end
      end
   end

   assign core_state = r_core_state;
   assign core_key   = r_core_key;

   // Ciphertext is passed straight through; the tag says whether it is live.
   assign rsp_valid = w_tag_valid && !rst;
   assign rsp_id    = w_tag_id;
   assign rsp_data  = core_out;
   assign busy      = !rst && (r_inflight != '0);
   assign drained   = !rst && (r_state == ST_DRAIN) && (r_inflight == '0);

endmodule
